// File: rtl/instr_trace_buffer.sv
// Instruction trace buffer: circular capture of the fetched instruction stream,
// masked-match trigger with post-trigger depth, frozen oldest-first readout.
module instr_trace_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned POST_COUNT = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] Instruction,
    input  logic                  InstrValid,
    input  logic                  Arm,
    input  logic                  Halt,
    input  logic [DATA_WIDTH-1:0] TrigValue,
    input  logic [DATA_WIDTH-1:0] TrigMask,
    input  logic                  RdEn,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  RdValid,
    output logic [ADDR_WIDTH:0]   Count,
    output logic [1:0]            State,
    output logic                  Triggered
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] POST  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic [CW-1:0]         count;
    logic                  triggered;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic match;
    logic capturing;
    logic wr_en;
    logic rd_ok;
    logic trig_hit;
    logic post_last;

    // Next-state and control decode; Arm dominates everything
    always_comb begin
        state_next = state;
        match      = InstrValid && (((Instruction ^ TrigValue) & TrigMask) == '0);
        capturing  = (state == ARMED) || (state == POST);
        wr_en      = !Arm && capturing && InstrValid;
        rd_ok      = !Arm && (state == DONE) && RdEn && (count != '0);
        trig_hit   = !Arm && (state == ARMED) && match && !Halt;
        post_last  = (state == POST) && InstrValid && (post_cnt == ADDR_WIDTH'(1));
        // Oldest entry sits Count slots behind the write pointer
        rd_ptr     = wr_ptr - count[ADDR_WIDTH-1:0];

        if (Arm) begin
            state_next = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (Halt)       state_next = DONE;
                    else if (match) state_next = (POST_COUNT == 0) ? DONE : POST;
                end
                POST: begin
                    if (Halt || post_last) state_next = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else if (Arm) begin
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                if (count != CW'(DEPTH)) count <= count + CW'(1);
            end
            if (rd_ok) begin
                count   <= count - CW'(1);
                rd_data <= mem[rd_ptr];
            end
            if (trig_hit) begin
                triggered <= 1'b1;
                post_cnt  <= ADDR_WIDTH'(POST_COUNT);
            end else if (wr_en && (state == POST)) begin
                post_cnt <= post_cnt - ADDR_WIDTH'(1);
            end
        end
    end

    // Storage has no reset; contents are meaningless until written
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr] <= Instruction;
    end

    assign State     = state;
    assign Count     = count;
    assign Triggered = triggered;
    assign RdValid   = rd_valid;
    assign RdData    = rd_data;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Bench for instr_trace_buffer: two DEPTH=8 instances (POST_COUNT 3 and 0) share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_instr_trace_buffer;

    localparam int DW = 32;
    localparam int DP = 8;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [DW-1:0] Instruction;
    logic          InstrValid;
    logic          Arm;
    logic          Halt;
    logic [DW-1:0] TrigValue;
    logic [DW-1:0] TrigMask;
    logic          RdEn;

    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic [3:0]    count0, count1;
    logic [1:0]    state0, state1;
    logic          trig0, trig1;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    instr_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(3), .POST_COUNT(3)) u0 (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InstrValid(InstrValid),
        .Arm(Arm), .Halt(Halt), .TrigValue(TrigValue), .TrigMask(TrigMask), .RdEn(RdEn),
        .RdData(rd_data0), .RdValid(rd_valid0), .Count(count0), .State(state0),
        .Triggered(trig0));

    instr_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(3), .POST_COUNT(0)) u1 (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InstrValid(InstrValid),
        .Arm(Arm), .Halt(Halt), .TrigValue(TrigValue), .TrigMask(TrigMask), .RdEn(RdEn),
        .RdData(rd_data1), .RdValid(rd_valid1), .Count(count1), .State(state1),
        .Triggered(trig1));

    // Reference model: captured words kept as an age-ordered queue per instance
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            m_state[2];
    int            m_post[2];
    int            m_trig[2];
    int            m_rdv[2];
    logic [DW-1:0] m_rdd[2];

    function automatic int post_n(int k);
        return (k == 0) ? 3 : 0;
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(int k, logic [DW-1:0] w);
        if (k == 0) begin
            if (q0.size() == DP) void'(q0.pop_front());
            q0.push_back(w);
        end else begin
            if (q1.size() == DP) void'(q1.pop_front());
            q1.push_back(w);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_post[k] = 0; m_trig[k] = 0; m_rdv[k] = 0; m_rdd[k] = '0;
        end
    endtask

    task automatic model_step(int k);
        logic hit;
        hit = InstrValid && (((Instruction ^ TrigValue) & TrigMask) == '0);
        m_rdv[k] = 0;
        if (Arm) begin
            if (k == 0) q0.delete(); else q1.delete();
            m_state[k] = 1; m_post[k] = 0; m_trig[k] = 0;
        end else begin
            case (m_state[k])
                1: begin
                    if (InstrValid) push(k, Instruction);
                    if (Halt) m_state[k] = 3;
                    else if (hit) begin
                        m_trig[k] = 1;
                        if (post_n(k) == 0) m_state[k] = 3;
                        else begin m_post[k] = post_n(k); m_state[k] = 2; end
                    end
                end
                2: begin
                    if (InstrValid) begin
                        push(k, Instruction);
                        m_post[k]--;
                        if (m_post[k] == 0) m_state[k] = 3;
                    end
                    if (Halt) m_state[k] = 3;
                end
                3: begin
                    if (RdEn && qsize(k) > 0) begin
                        m_rdd[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
                        m_rdv[k] = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("u0_state", DW'(state0), DW'(m_state[0]));
        check("u0_count", DW'(count0), DW'(qsize(0)));
        check("u0_trig",  DW'(trig0), DW'(m_trig[0]));
        check("u0_rdv",   DW'(rd_valid0), DW'(m_rdv[0]));
        check("u0_rdd",   rd_data0, m_rdd[0]);
        check("u1_state", DW'(state1), DW'(m_state[1]));
        check("u1_count", DW'(count1), DW'(qsize(1)));
        check("u1_trig",  DW'(trig1), DW'(m_trig[1]));
        check("u1_rdv",   DW'(rd_valid1), DW'(m_rdv[1]));
        check("u1_rdd",   rd_data1, m_rdd[1]);
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (Rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare_all();
    endtask

    task automatic feed(logic [DW-1:0] w);
        Instruction = w;
        InstrValid  = 1'b1;
        cycle();
        InstrValid  = 1'b0;
    endtask

    task automatic arm();
        Arm = 1'b1;
        InstrValid = 1'b0;
        cycle();
        Arm = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Instruction = '0; InstrValid = 1'b0; Arm = 1'b0; Halt = 1'b0;
        TrigValue = 32'h0000_000A; TrigMask = 32'hFFFF_FFFF; RdEn = 1'b0;
        model_reset();
        #1;
        compare_all();
        cycle();
        cycle();
        Rst = 1'b0;
        cycle();

        // Async reset while armed with 5 words held
        arm();
        for (int i = 1; i <= 5; i++) feed(DW'(i));
        check("pre_rst_count", DW'(count0), 32'd5);
        #2 Rst = 1'b1;
        #1;
        check("arst_state", DW'(state0), 32'd0);
        check("arst_count", DW'(count0), 32'd0);
        check("arst_trig",  DW'(trig0), 32'd0);
        cycle();
        Rst = 1'b0;

        // Exact-match trigger at 0xA, wrap-around, oldest-first readout
        arm();
        for (int i = 1; i <= 20; i++) feed(DW'(i));
        check("t2_state", DW'(state0), 32'd3);
        check("t2_count", DW'(count0), 32'd8);
        check("t2_trig",  DW'(trig0), 32'd1);
        check("t2_u1_count", DW'(count1), 32'd8);
        RdEn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("t2_rdv", DW'(rd_valid0), 32'd1);
            check("t2_rdd", rd_data0, DW'(6 + i));
        end
        RdEn = 1'b0;
        cycle();
        check("t2_empty", DW'(count0), 32'd0);
        check("t2_rdv_off", DW'(rd_valid0), 32'd0);

        // Zero mask triggers on the first valid word
        TrigMask = '0;
        arm();
        for (int i = 1; i <= 8; i++) feed(DW'(i));
        check("t3_state", DW'(state0), 32'd3);
        check("t3_count", DW'(count0), 32'd4);
        check("t3_u1_state", DW'(state1), 32'd3);
        check("t3_u1_count", DW'(count1), 32'd1);
        RdEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t3_rdd", rd_data0, DW'(1 + i));
        end
        RdEn = 1'b0;
        cycle();

        // Halt with the 4th word, then over-long read burst
        TrigMask = 32'hFFFF_FFFF;
        arm();
        for (int i = 1; i <= 3; i++) feed(DW'(i));
        Halt = 1'b1;
        feed(32'd4);
        Halt = 1'b0;
        check("t4_state", DW'(state0), 32'd3);
        check("t4_count", DW'(count0), 32'd4);
        check("t4_trig",  DW'(trig0), 32'd0);
        RdEn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("t4_rdv", DW'(rd_valid0), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) check("t4_rdd", rd_data0, DW'(1 + i));
        end
        RdEn = 1'b0;

        // Arm in DONE beats a simultaneous read and valid word
        arm();
        for (int i = 1; i <= 4; i++) feed(DW'(i));
        Halt = 1'b1;
        feed(32'd5);
        Halt = 1'b0;
        check("t5_count", DW'(count0), 32'd5);
        Arm = 1'b1; RdEn = 1'b1; InstrValid = 1'b1; Instruction = 32'h0000_000A;
        cycle();
        Arm = 1'b0; RdEn = 1'b0; InstrValid = 1'b0;
        check("t5_state", DW'(state0), 32'd1);
        check("t5_count", DW'(count0), 32'd0);
        check("t5_rdv",   DW'(rd_valid0), 32'd0);
        cycle();
        check("t5_count2", DW'(count0), 32'd0);

        // Matching word on an invalid cycle must not trigger
        arm();
        Instruction = 32'h1; InstrValid = 1'b1; cycle();
        Instruction = 32'hA; InstrValid = 1'b0; cycle();
        Instruction = 32'h2; InstrValid = 1'b1; cycle();
        Instruction = 32'hA; InstrValid = 1'b0; cycle();
        check("t6_state", DW'(state0), 32'd1);
        check("t6_count", DW'(count0), 32'd2);
        check("t6_trig",  DW'(trig0), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            Rst         = ($urandom_range(0, 499) == 0);
            Arm         = ($urandom_range(0, 24) == 0);
            Halt        = ($urandom_range(0, 39) == 0);
            InstrValid  = $urandom_range(0, 1) == 1;
            RdEn        = $urandom_range(0, 1) == 1;
            Instruction = DW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) Instruction = Instruction | (DW'($urandom()) << 4);
            if (Arm) begin
                case ($urandom_range(0, 2))
                    0:       TrigMask = 32'hFFFF_FFFF;
                    1:       TrigMask = 32'h0000_000F;
                    default: TrigMask = '0;
                endcase
                TrigValue = DW'($urandom_range(0, 15));
            end
            cycle();
        end
        Rst = 1'b0; Arm = 1'b0; Halt = 1'b0; InstrValid = 1'b0; RdEn = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_trace_buffer.md
Name: instr_trace_buffer

Overview:
- Parametrised capture buffer that records the processor's fetched instruction stream into a circular memory.
- Triggers on a masked instruction match, records a fixed number of post-trigger words, then freezes.
- Frozen contents are read out oldest-first through a read handshake.
- Sits beside the datapath/controller top-level and taps its Instruction output. Used for bring-up and self-checking benches in place of waveform inspection.

Parameters:
- DATA_WIDTH, 32: width of the captured instruction word.
- DEPTH, 16: number of buffer entries; must be a power of two and at least 2.
- ADDR_WIDTH, 4: log2(DEPTH).
- POST_COUNT, 4: number of words stored after the trigger word; range 0..DEPTH-1.

Ports:
- Clk, input, 1: single system clock; all logic is rising-edge.
- Rst, input, 1: asynchronous, active-high reset.
- Instruction, input, DATA_WIDTH: instruction word from the processor.
- InstrValid, input, 1: Instruction is a new fetched word this cycle.
- Arm, input, 1: single-cycle pulse; clears the buffer and starts a capture.
- Halt, input, 1: forces an immediate freeze (DONE).
- TrigValue, input, DATA_WIDTH: trigger compare value.
- TrigMask, input, DATA_WIDTH: 1 = bit participates in the compare.
- RdEn, input, 1: read request, honoured only in DONE.
- RdData, output, DATA_WIDTH: read data.
- RdValid, output, 1: RdData valid this cycle.
- Count, output, ADDR_WIDTH+1: number of unread entries held.
- State, output, 2: IDLE=0, ARMED=1, POST=2, DONE=3.
- Triggered, output, 1: sticky; trigger seen since the last Arm.

Behaviour:
- Reset (async, Rst=1): State=IDLE, Count=0, RdData=0, RdValid=0, Triggered=0, write/read pointers=0, post counter=0. Memory contents are don't-care. Reset mid-capture or mid-readout discards everything.
- Match condition: InstrValid && (((Instruction ^ TrigValue) & TrigMask) == 0). A TrigMask of 0 matches any valid word.
- IDLE: ignores InstrValid and RdEn. Arm goes to ARMED.
- ARMED: each InstrValid word is written at wr_ptr; wr_ptr increments modulo DEPTH; Count increments and saturates at DEPTH, so the oldest entry is overwritten once full.
  - On a match, the matching word is stored, Triggered is set next cycle, post counter = POST_COUNT, and the state goes to POST. If POST_COUNT=0, the state goes straight to DONE.
- POST: each InstrValid word is stored as in ARMED and the post counter decrements. The store that brings the counter to 0 transitions to DONE. Further matches in POST are ignored.
- DONE: no writes. The read pointer is (wr_ptr - Count) mod DEPTH, i.e. oldest-first readout.
  - RdEn with Count>0: RdData = entry at the read pointer, RdValid=1 exactly one cycle later; the read pointer increments and Count decrements.
  - RdEn with Count=0: ignored, RdValid=0.
  - RdEn held high streams one word per cycle.
- Halt: in ARMED or POST, goes to DONE at the next edge. The InstrValid word in the same cycle is still stored; Triggered is unchanged. Halt in IDLE or DONE has no effect.
- Arm: accepted in any state and has highest priority over Halt, match and RdEn.
  - Next cycle: Count=0, pointers=0, Triggered=0, RdValid=0, State=ARMED.
  - The InstrValid word in the Arm cycle is NOT stored.
- Latency: a word presented in cycle N is counted in Count at N+1. Read data appears one cycle after RdEn.
- RdValid is a single-cycle pulse per accepted read. RdData holds its last value otherwise.
- Width rule: Count is ADDR_WIDTH+1 bits so it can represent DEPTH exactly.

Test Plan:
- Reset during ARMED after 5 stored words -> State=0, Count=0, Triggered=0 immediately (async, no clock edge needed).
- DEPTH=8, POST_COUNT=3, TrigMask=FFFFFFFF, TrigValue=0x0000000A; Arm, then feed 0x1..0x14 with InstrValid=1 every cycle -> trigger at 0xA, DONE after 0xD is stored, Count=8. Readout returns 0x6,0x7,0x8,0x9,0xA,0xB,0xC,0xD, then Count=0.
- Same configuration with TrigMask=0 -> trigger on the first word 0x1, DONE after 0x4, Count=4, readout 0x1..0x4. With POST_COUNT=0, DONE after 0x1 and Count=1.
- Arm, feed 3 words with no match, assert Halt together with the 4th word -> DONE, Count=4, Triggered=0. RdEn held 6 cycles -> 4 RdValid pulses (0x1..0x4), then RdValid stays 0.
- Assert Arm in DONE with Count=5 and the same cycle RdEn=1 and InstrValid=1 -> next cycle ARMED, Count=0, RdValid=0, no word stored.
- InstrValid toggling 1,0,1,0 in ARMED with a matching word on a low-valid cycle -> no trigger; Count increments only on valid cycles.
